// File: rtl/uart_tx_buffer.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_buffer
// Purpose  : Byte FIFO plus drain state machine that sits between the MMIO
//            to_host write decode and the UARTTX serializer. The processor
//            pushes bytes without polling per character. The drain FSM pops
//            one byte at a time and hands it to UARTTX with a one-cycle
//            write strobe.
// Revision : 1.0 - initial release
//
// Parameters:
//   DEPTH_LOG - log2 of the FIFO depth (1..7)
//   GUARD     - number of cycles after tx_we during which tx_ready is
//               ignored, which covers the READY fall latency of UARTTX (1..15)
//
// Optional build macro:
//   UART_TX_CRLF_EN - when defined, a popped LF (8'h0A) is sent as CR then LF.
//
// Ports:
//   clk      in   1  system clock
//   rst      in   1  synchronous active-high reset
//   wr_en    in   1  push request (MMIO to_host store)
//   wr_data  in   8  byte to push
//   clr_ovf  in   1  clears the overflow flag and the drop counter
//   full     out  1  FIFO holds 2^DEPTH_LOG entries
//   empty    out  1  FIFO holds no entries
//   status   out 32  MMIO read word:
//                    [0]=!full [1]=empty [2]=overflow [3]=busy
//                    [15:8]=count [31:16]=drop_cnt, all other bits 0
//   tx_data  out  8  byte for UARTTX DATA
//   tx_we    out  1  one-cycle write strobe for UARTTX WE
//   tx_ready in   1  UARTTX READY
// ============================================================================
module uart_tx_buffer #(
    parameter int DEPTH_LOG = 4,
    parameter int GUARD     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    input  logic        clr_ovf,
    output logic        full,
    output logic        empty,
    output logic [31:0] status,
    output logic [7:0]  tx_data,
    output logic        tx_we,
    input  logic        tx_ready
);

    localparam int                 c_DEPTH      = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] c_FULL_CNT   = (DEPTH_LOG + 1)'(c_DEPTH);
    localparam logic [DEPTH_LOG:0] c_CNT_ONE    = (DEPTH_LOG + 1)'(1);
    localparam logic [DEPTH_LOG-1:0] c_PTR_ONE  = DEPTH_LOG'(1);
    localparam logic [3:0]         c_GUARD_LOAD = 4'(GUARD - 1);
    localparam logic [15:0]        c_DROP_MAX   = 16'hFFFF;
    localparam logic [7:0]         c_CR         = 8'h0D;
    localparam logic [7:0]         c_LF         = 8'h0A;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_GUARD_WAIT = 2'd1,
`ifdef UART_TX_CRLF_EN
        S_WAIT_RDY   = 2'd2,
        S_LF_PEND    = 2'd3
`else
        S_WAIT_RDY   = 2'd2
`endif
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [7:0]           mem_q [c_DEPTH];
    logic [DEPTH_LOG-1:0] wr_ptr_q,    wr_ptr_d;
    logic [DEPTH_LOG-1:0] rd_ptr_q,    rd_ptr_d;
    logic [DEPTH_LOG:0]   count_q,     count_d;
    logic                 overflow_q,  overflow_d;
    logic [15:0]          drop_cnt_q,  drop_cnt_d;
    state_t               state_q,     state_d;
    logic [3:0]           guard_cnt_q, guard_cnt_d;
    logic [7:0]           tx_data_q,   tx_data_d;
    logic                 tx_we_q,     tx_we_d;
`ifdef UART_TX_CRLF_EN
    logic                 lf_pend_q,   lf_pend_d;
`endif

    logic       w_pop;
    logic       w_push;
    logic       w_drop;
    logic [7:0] w_head;

    // Flags decode straight from the count register so nothing on an input
    // can reach an output combinationally.
    assign full   = (count_q == c_FULL_CNT);
    assign empty  = (count_q == '0);
    assign w_head = mem_q[rd_ptr_q];

    // ------------------------------------------------------------------------
    // Drain FSM: next state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        guard_cnt_d = guard_cnt_q;
        tx_data_d   = tx_data_q;
        tx_we_d     = 1'b0;
        w_pop       = 1'b0;
`ifdef UART_TX_CRLF_EN
        lf_pend_d   = lf_pend_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (!empty && tx_ready) begin
                    w_pop       = 1'b1;
                    tx_we_d     = 1'b1;
                    tx_data_d   = w_head;
                    guard_cnt_d = c_GUARD_LOAD;
                    state_d     = S_GUARD_WAIT;
`ifdef UART_TX_CRLF_EN
                    // LF goes out as CR first; the LF itself is replayed from
                    // the pending flag without a second pop.
                    if (w_head == c_LF) begin
                        tx_data_d = c_CR;
                        lf_pend_d = 1'b1;
                    end
`endif
                end
            end

            S_GUARD_WAIT: begin
                // tx_ready is stale right after a strobe; wait it out.
                if (guard_cnt_q == '0) begin
                    state_d = S_WAIT_RDY;
                end else begin
                    guard_cnt_d = guard_cnt_q - 4'd1;
                end
            end

            S_WAIT_RDY: begin
                if (tx_ready) begin
`ifdef UART_TX_CRLF_EN
                    state_d = lf_pend_q ? S_LF_PEND : S_IDLE;
`else
                    state_d = S_IDLE;
`endif
                end
            end

`ifdef UART_TX_CRLF_EN
            S_LF_PEND: begin
                // READY was already seen in WAIT_RDY, so send immediately.
                tx_we_d     = 1'b1;
                tx_data_d   = c_LF;
                lf_pend_d   = 1'b0;
                guard_cnt_d = c_GUARD_LOAD;
                state_d     = S_GUARD_WAIT;
            end
`endif

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FIFO bookkeeping and diagnostics
    // ------------------------------------------------------------------------
    always_comb begin
        // A pop in the same cycle frees a slot, so a full FIFO still accepts.
        w_push     = wr_en && (!full || w_pop);
        w_drop     = wr_en && full && !w_pop;

        wr_ptr_d   = w_push ? (wr_ptr_q + c_PTR_ONE) : wr_ptr_q;
        rd_ptr_d   = w_pop  ? (rd_ptr_q + c_PTR_ONE) : rd_ptr_q;

        count_d    = count_q;
        if (w_push && !w_pop) begin
            count_d = count_q + c_CNT_ONE;
        end else if (!w_push && w_pop) begin
            count_d = count_q - c_CNT_ONE;
        end

        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        // The clear takes priority over a drop in the same cycle.
        if (clr_ovf) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else if (w_drop) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != c_DROP_MAX) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= '0;
            state_q     <= S_IDLE;
            guard_cnt_q <= '0;
            tx_data_q   <= 8'h00;
            tx_we_q     <= 1'b0;
`ifdef UART_TX_CRLF_EN
            lf_pend_q   <= 1'b0;
`endif
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            drop_cnt_q  <= drop_cnt_d;
            state_q     <= state_d;
            guard_cnt_q <= guard_cnt_d;
            tx_data_q   <= tx_data_d;
            tx_we_q     <= tx_we_d;
`ifdef UART_TX_CRLF_EN
            lf_pend_q   <= lf_pend_d;
`endif
        end
    end

    // Storage array needs no reset: validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign tx_data = tx_data_q;
    assign tx_we   = tx_we_q;
    assign status  = {drop_cnt_q,
                      8'(count_q),
                      4'b0000,
                      (state_q != S_IDLE),
                      overflow_q,
                      empty,
                      !full};

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_buffer
// Purpose  : Self-checking bench for uart_tx_buffer. A scoreboard queue holds
//            the bytes expected on tx_data; a monitor pops it on every tx_we
//            and also checks strobe width and spacing. A table of per-cycle
//            vectors covers fill, overflow and clear; hand-written sequences
//            cover pop/push collision, reset mid-drain, wrap and CR/LF.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_buffer;

    localparam int c_DL    = 4;
    localparam int c_GUARD = 2;
    localparam int c_DEPTH = 1 << c_DL;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        clr_ovf;
    logic        full;
    logic        empty;
    logic [31:0] status;
    logic [7:0]  tx_data;
    logic        tx_we;
    logic        tx_ready;

    // UARTTX model: READY low for 10 cycles after WE, or manual override.
    logic auto_mode;
    logic ready_man;
    int   ucnt = 0;
    assign tx_ready = auto_mode ? (ucnt == 0) : ready_man;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tx_we)        ucnt <= 10;
        else if (ucnt > 0) ucnt <= ucnt - 1;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_buffer #(.DEPTH_LOG(c_DL), .GUARD(c_GUARD)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .clr_ovf  (clr_ovf),
        .full     (full),
        .empty    (empty),
        .status   (status),
        .tx_data  (tx_data),
        .tx_we    (tx_we),
        .tx_ready (tx_ready)
    );

    int         errors = 0;
    int         checks = 0;
    int         we_count = 0;
    int         last_we_cyc = -100;
    logic       prev_we = 1'b0;
    logic [7:0] sb_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the scoreboard head.
    always @(negedge clk) begin
        if (tx_we === 1'b1) begin
            we_count++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_tx_we: got data %h expected no strobe", tx_data);
            end else begin
                logic [7:0] exp_b;
                exp_b = sb_q.pop_front();
                chk("tx_data", {24'h0, tx_data}, {24'h0, exp_b});
            end
            chk("we_width", {31'h0, prev_we}, 32'h0);
            chk("we_spacing", {31'h0, ((cyc - last_we_cyc) >= (c_GUARD + 2))}, 32'h1);
            last_we_cyc = cyc;
        end
        prev_we = tx_we;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_b(input logic [7:0] b);
`ifdef UART_TX_CRLF_EN
        if (b == 8'h0A) begin
            sb_q.push_back(8'h0D);
            sb_q.push_back(8'h0A);
        end else begin
            sb_q.push_back(b);
        end
`else
        sb_q.push_back(b);
`endif
    endtask

    task automatic push(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (sb_q.size() == 0 && empty && !status[3]) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        chk(name, {31'h0, done}, 32'h1);
    endtask

    typedef struct {
        logic        wr_en;
        logic [7:0]  data;
        logic        clr;
        logic        acc;
        logic        exp_full;
        logic [31:0] exp_status;
    } vec_t;

    vec_t vecs[21];

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Table for the fill / overflow / clear sequence (tx_ready held low).
        for (int i = 0; i < c_DEPTH; i++) begin
            vecs[i] = '{1'b1, 8'(8'h10 + i), 1'b0, 1'b1, (i == c_DEPTH - 1),
                        (32'((i + 1)) << 8) | ((i == c_DEPTH - 1) ? 32'h0 : 32'h1)};
        end
        vecs[16] = '{1'b1, 8'hEE, 1'b0, 1'b0, 1'b1, 32'h0001_1004}; // dropped
        vecs[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 32'h0000_1000}; // clear
        vecs[18] = '{1'b1, 8'hEF, 1'b1, 1'b0, 1'b1, 32'h0000_1000}; // clear wins
        vecs[19] = '{1'b1, 8'hF0, 1'b0, 1'b0, 1'b1, 32'h0001_1004}; // dropped
        vecs[20] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 32'h0000_1000}; // clear

        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; clr_ovf = 1'b0;
        auto_mode = 1'b1; ready_man = 1'b0;
        repeat (3) tick();
        chk("rst_status",  status,          32'h0000_0003);
        chk("rst_tx_we",   {31'h0, tx_we},  32'h0);
        chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
        chk("rst_empty",   {31'h0, empty},  32'h1);
        chk("rst_full",    {31'h0, full},   32'h0);
        rst = 1'b0;
        tick();

        // Back-to-back pushes with the UARTTX model.
        expect_b(8'h41); push(8'h41);
        expect_b(8'h42); push(8'h42);
        expect_b(8'h43); push(8'h43);
        wait_drain("t1_drain");
        chk("t1_status", status, 32'h0000_0003);

        // Fill, overflow and clear with tx_ready low.
        auto_mode = 1'b0; ready_man = 1'b0;
        for (int i = 0; i < 21; i++) begin
            wr_en   = vecs[i].wr_en;
            wr_data = vecs[i].data;
            clr_ovf = vecs[i].clr;
            if (vecs[i].acc) expect_b(vecs[i].data);
            tick();
            wr_en = 1'b0; clr_ovf = 1'b0;
            chk($sformatf("vec%0d_status", i), vecs[i].exp_status, status);
            chk($sformatf("vec%0d_full", i), {31'h0, full}, {31'h0, vecs[i].exp_full});
        end

        // Full FIFO: first pop and a push in the same cycle.
        ready_man = 1'b1; wr_en = 1'b1; wr_data = 8'hA5;
        expect_b(8'hA5);
        tick();
        wr_en = 1'b0; ready_man = 1'b0;
        chk("t3_status", status, 32'h0000_1008);
        auto_mode = 1'b1;
        wait_drain("t3_drain");
        chk("t3_end_status", status, 32'h0000_0003);

        // Reset while bytes are queued and the FSM is in its guard window.
        auto_mode = 1'b0; ready_man = 1'b0;
        for (int i = 0; i < 5; i++) begin
            expect_b(8'(8'h50 + i));
            push(8'(8'h50 + i));
        end
        ready_man = 1'b1;
        tick();
        ready_man = 1'b0;
        chk("t4_busy", {31'h0, status[3]}, 32'h1);
        rst = 1'b1;
        tick();
        sb_q.delete();
        chk("t4_status", status, 32'h0000_0003);
        chk("t4_tx_we", {31'h0, tx_we}, 32'h0);
        chk("t4_empty", {31'h0, empty}, 32'h1);
        rst = 1'b0;
        ready_man = 1'b1;
        begin
            int wc;
            wc = we_count;
            repeat (20) tick();
            chk("t4_no_we", we_count, wc);
        end

        // Pointer wrap: fill and drain three times.
        for (int r = 0; r < 3; r++) begin
            auto_mode = 1'b0; ready_man = 1'b0;
            for (int i = 0; i < c_DEPTH; i++) begin
                expect_b(8'(8'h80 + r * 16 + i));
                push(8'(8'h80 + r * 16 + i));
            end
            chk($sformatf("t5_full%0d", r), {31'h0, full}, 32'h1);
            auto_mode = 1'b1;
            wait_drain($sformatf("t5_drain%0d", r));
        end

        // LF handling (CR inserted only when the option is built in).
        expect_b(8'h61); push(8'h61);
        expect_b(8'h0A); push(8'h0A);
        wait_drain("t6_drain");
        chk("t6_status", status, 32'h0000_0003);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
